flutter_ctrl: RTL and testbench



---
 rtl/flutter_ctrl.sv | 163 ++++++++++++++++
 tb/tb_flutter_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flutter_ctrl.sv
// flutter_ctrl: command sequencer for the scrolling 4-digit display,
// plus the digit scan scheduler that shares one 7-segment decoder.
module flutter_ctrl #(
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned SCROLL_DIV = 50000000
) (
    input  logic       clk100mhz,
    input  logic       clr,
    input  logic       sw_add,
    input  logic       sw_left,
    input  logic       enable,
    output logic [3:0] pos,
    output logic [3:0] digit,
    output logic       busy
);
    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned SCRL_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SCRL_W-1:0] SCRL_LAST = SCRL_W'(SCROLL_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_ROT,
        S_HOLD
    } state_e;

    state_e            state_q, state_d;
    logic              rot_left_q, rot_left_d;
    logic [1:0]        add_sync_q, left_sync_q;
    logic              add_prev_q, left_prev_q;
    logic              add_pend_q, add_pend_d;
    logic              left_pend_q, left_pend_d;
    logic              auto_pend_q, auto_pend_d;
    logic [SCRL_W-1:0] scrl_cnt_q, scrl_cnt_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0]        pos_q, pos_d;
    logic [3:0]        digit_q, digit_d;
    logic [3:0]        d_q [4];
    logic [3:0]        d_d [4];

    logic add_edge, left_edge;
    logic do_add, do_rot;
    logic clr_add, clr_left, clr_auto;
    logic scan_term;

    assign add_edge  = add_sync_q[1] & ~add_prev_q;
    assign left_edge = left_sync_q[1] & ~left_prev_q;

    always_comb begin
        state_d    = state_q;
        rot_left_d = rot_left_q;
        do_add     = 1'b0;
        do_rot     = 1'b0;
        clr_add    = 1'b0;
        clr_left   = 1'b0;
        clr_auto   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (add_pend_q) begin
                    state_d = S_ADD;
                end else if (left_pend_q) begin
                    state_d    = S_ROT;
                    rot_left_d = 1'b1;
                end else if (auto_pend_q) begin
                    state_d    = S_ROT;
                    rot_left_d = 1'b0;
                end
            end
            S_ADD: begin
                do_add  = 1'b1;
                clr_add = 1'b1;
                state_d = S_HOLD;
            end
            S_ROT: begin
                do_rot   = 1'b1;
                clr_left = rot_left_q;
                clr_auto = ~rot_left_q;
                state_d  = S_HOLD;
            end
            S_HOLD:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A new edge wins over a same-cycle clear so no command is dropped.
    always_comb begin
        add_pend_d  = add_edge | (add_pend_q & ~clr_add);
        left_pend_d = left_edge | (left_pend_q & ~clr_left);
        auto_pend_d = auto_pend_q & ~clr_auto;
        scrl_cnt_d  = scrl_cnt_q + SCRL_W'(1);
        if (!enable) begin
            scrl_cnt_d  = '0;
            auto_pend_d = 1'b0;
        end else if (scrl_cnt_q == SCRL_LAST) begin
            scrl_cnt_d  = '0;
            auto_pend_d = 1'b1;
        end
    end

    always_comb begin
        d_d = d_q;
        if (do_add) begin
            d_d[0] = d_q[0] + 4'd1;
        end
        if (do_rot) begin
            d_d[0] = d_q[3];
            d_d[1] = d_q[0];
            d_d[2] = d_q[1];
            d_d[3] = d_q[2];
        end
    end

    always_comb begin
        scan_term  = (scan_cnt_q == SCAN_LAST);
        scan_cnt_d = scan_term ? '0 : scan_cnt_q + SCAN_W'(1);
        idx_d      = scan_term ? idx_q + 2'd1 : idx_q;
        pos_d      = ~(4'b0001 << idx_q);
        digit_d    = d_q[idx_q];
    end

    always_ff @(posedge clk100mhz or negedge clr) begin
        if (!clr) begin
            state_q     <= S_IDLE;
            rot_left_q  <= 1'b0;
            add_sync_q  <= '0;
            left_sync_q <= '0;
            add_prev_q  <= 1'b0;
            left_prev_q <= 1'b0;
            add_pend_q  <= 1'b0;
            left_pend_q <= 1'b0;
            auto_pend_q <= 1'b0;
            scrl_cnt_q  <= '0;
            scan_cnt_q  <= '0;
            idx_q       <= '0;
            pos_q       <= 4'b1110;
            digit_q     <= '0;
            d_q         <= '{default: 4'h0};
        end else begin
            state_q     <= state_d;
            rot_left_q  <= rot_left_d;
            add_sync_q  <= {add_sync_q[0], sw_add};
            left_sync_q <= {left_sync_q[0], sw_left};
            add_prev_q  <= add_sync_q[1];
            left_prev_q <= left_sync_q[1];
            add_pend_q  <= add_pend_d;
            left_pend_q <= left_pend_d;
            auto_pend_q <= auto_pend_d;
            scrl_cnt_q  <= scrl_cnt_d;
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            pos_q       <= pos_d;
            digit_q     <= digit_d;
            d_q         <= d_d;
        end
    end

    assign pos   = pos_q;
    assign digit = digit_q;
    assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_flutter_ctrl.sv
// tb_flutter_ctrl: random and directed commands against a word-level
// model of the pattern buffer, observed through the scanned display.
module tb_flutter_ctrl;
    logic       clk = 1'b0;
    logic       clr;
    logic       sw_add;
    logic       sw_left;
    logic       enable;
    logic [3:0] pos;
    logic [3:0] digit;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    // model buffer as a word {d3,d2,d1,d0}
    logic [15:0] mw;

    flutter_ctrl #(
        .SCAN_DIV  (2),
        .SCROLL_DIV(8)
    ) dut (
        .clk100mhz(clk),
        .clr      (clr),
        .sw_add   (sw_add),
        .sw_left  (sw_left),
        .enable   (enable),
        .pos      (pos),
        .digit    (digit),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] m_add(input logic [15:0] w);
        logic [3:0] n;
        n = w[3:0] + 4'd1;
        return {w[15:4], n};
    endfunction

    function automatic logic [15:0] m_rot(input logic [15:0] w);
        return {w[11:0], w[15:12]};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        clr     = 1'b0;
        sw_add  = 1'b0;
        sw_left = 1'b0;
        enable  = 1'b0;
        repeat (3) @(negedge clk);
        clr = 1'b1;
        mw  = '0;
    endtask

    task automatic read_buf(input string tag, input logic [15:0] exp);
        logic [3:0]  seen;
        logic [15:0] w;
        seen = '0;
        w    = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            case (pos)
                4'b1110: begin w[3:0]   = digit; seen[0] = 1'b1; end
                4'b1101: begin w[7:4]   = digit; seen[1] = 1'b1; end
                4'b1011: begin w[11:8]  = digit; seen[2] = 1'b1; end
                4'b0111: begin w[15:12] = digit; seen[3] = 1'b1; end
                default: ;
            endcase
        end
        check("scan_cover", {28'd0, seen}, 32'hF);
        check(tag, {16'd0, w}, {16'd0, exp});
    endtask

    task automatic pulse(input bit is_add, input int w);
        int lat;
        int blen;
        lat  = 0;
        blen = 0;
        @(negedge clk);
        if (is_add) sw_add = 1'b1;
        else sw_left = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 12; k++) begin
            if (k == w) begin
                sw_add  = 1'b0;
                sw_left = 1'b0;
            end
            @(posedge clk);
            #1;
            if (busy) begin
                blen++;
                if (lat == 0) lat = k;
            end
        end
        check(is_add ? "add_lat" : "rot_lat", lat, 3);
        check("busy_len", blen, 2);
    endtask

    task automatic drive_seq(input logic [15:0] a, input logic [15:0] l,
                             output logic [31:0] bh);
        bh = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            sw_add  = a[i];
            sw_left = l[i];
            @(posedge clk);
            #1;
            bh[i] = busy;
        end
        @(negedge clk);
        sw_add  = 1'b0;
        sw_left = 1'b0;
        for (int i = 16; i < 28; i++) begin
            @(posedge clk);
            #1;
            bh[i] = busy;
        end
    endtask

    task automatic busy_hist(input int n, output logic [31:0] bh);
        bh = '0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            bh[k] = busy;
        end
    endtask

    initial begin
        logic [31:0] bh;
        logic [3:0]  ep;
        int          j;
        int          cnt;
        bit          cmd;

        clr     = 1'b0;
        sw_add  = 1'b0;
        sw_left = 1'b0;
        enable  = 1'b0;
        mw      = '0;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sw_add  = 1'($urandom);
            sw_left = 1'($urandom);
            enable  = 1'($urandom);
            #1;
            check("rst_pos", {28'd0, pos}, 32'hE);
            check("rst_digit", {28'd0, digit}, 32'h0);
            check("rst_busy", {31'd0, busy}, 32'h0);
        end
        @(negedge clk);
        sw_add  = 1'b0;
        sw_left = 1'b0;
        enable  = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            j  = ((k - 1) / 2) % 4;
            ep = 4'b0001 << j;
            ep = ~ep;
            check("scan_pos", {28'd0, pos}, {28'd0, ep});
            check("scan_digit", {28'd0, digit}, 32'h0);
        end

        for (int i = 0; i < 4; i++) begin
            pulse(1'b1, 1);
            mw = m_add(mw);
        end
        read_buf("add4", 16'h0004);

        do_reset();
        for (int i = 0; i < 17; i++) begin
            pulse(1'b1, 1 + (i % 3));
            mw = m_add(mw);
        end
        read_buf("add17_wrap", 16'h0001);

        do_reset();
        for (int i = 0; i < 3; i++) begin
            pulse(1'b1, 1);
            mw = m_add(mw);
        end
        for (int i = 0; i < 5; i++) begin
            pulse(1'b0, 1);
            mw = m_rot(mw);
            read_buf("rot_step", mw);
        end
        read_buf("rot_final", 16'h0030);

        do_reset();
        for (int i = 0; i < 2; i++) begin
            pulse(1'b1, 1);
            mw = m_add(mw);
        end
        drive_seq(16'h0001, 16'h0005, bh);
        check("simul_busy", bh, 32'h0000_00D8);
        mw = m_rot(m_add(mw));
        read_buf("simul_buf", mw);
        drive_seq(16'h000A, 16'h0001, bh);
        check("coalesce_busy", bh, 32'h0000_00D8);
        mw = m_add(m_rot(mw));
        read_buf("coalesce_buf", mw);

        do_reset();
        for (int i = 0; i < 24; i++) begin
            cmd = 1'($urandom);
            pulse(cmd, int'($urandom_range(1, 3)));
            mw = cmd ? m_add(mw) : m_rot(mw);
            if (i % 6 == 5) read_buf("rand_buf", mw);
        end

        do_reset();
        pulse(1'b1, 1);
        mw = m_add(mw);
        @(negedge clk);
        enable = 1'b1;
        busy_hist(28, bh);
        check("auto_busy", bh, 32'h0606_0600);
        @(negedge clk);
        enable = 1'b0;
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (busy) cnt++;
        end
        check("auto_stop", cnt, 0);
        for (int i = 0; i < 3; i++) mw = m_rot(mw);
        read_buf("auto_buf", mw);
        @(negedge clk);
        enable = 1'b1;
        busy_hist(12, bh);
        check("auto_restart", bh, 32'h0000_0600);
        @(negedge clk);
        enable = 1'b0;
        mw = m_rot(mw);
        read_buf("auto_buf2", mw);

        do_reset();
        pulse(1'b1, 1);
        mw = m_add(mw);
        @(negedge clk);
        sw_left = 1'b1;
        @(posedge clk);
        #1;
        sw_left = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("in_rot", {31'd0, busy}, 32'h1);
        clr = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'h0);
        check("mid_rst_pos", {28'd0, pos}, 32'hE);
        check("mid_rst_digit", {28'd0, digit}, 32'h0);
        repeat (2) @(negedge clk);
        clr = 1'b1;
        mw  = '0;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (busy) cnt++;
        end
        check("mid_rst_idle", cnt, 0);
        read_buf("mid_rst_buf", mw);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
